// File: rtl/cond_unit.sv
// Condition-check unit: evaluates the instruction condition against the registered NZCV flags,
// qualifies write enables and updates the flags. Optional counters are enabled by COND_UNIT_STATS_EN.
module cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NoWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic [3:0]  Flags,
`ifdef COND_UNIT_STATS_EN
  output logic [15:0] exec_count,
  output logic [15:0] squash_count,
`endif
  output logic        undef_o
);

  logic [3:0] r_flags;
  logic       r_undef;
  logic       w_commit;
  logic       w_cond_ex;
  logic       w_n, w_z, w_c, w_v;

  assign w_commit = valid_i & ~stall_i & ~reset;
  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluated against the pre-update flags; no same-cycle bypass from ALUFlags.
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
      r_undef <= 1'b0;
    end else begin
      if (w_commit & w_cond_ex & FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (w_commit & w_cond_ex & FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
      if (w_commit && (Cond == 4'b1111)) r_undef <= 1'b1;
    end
  end

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_cond_ex & w_commit;
  assign MemWrite = MemW & w_cond_ex & w_commit;
  assign RegWrite = RegW & ~NoWrite & w_cond_ex & w_commit;
  assign Flags    = r_flags;
  assign undef_o  = r_undef;

`ifdef COND_UNIT_STATS_EN
  logic [15:0] r_exec_count;
  logic [15:0] r_squash_count;

  // Saturating counters: hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec_count   <= 16'd0;
      r_squash_count <= 16'd0;
    end else if (w_commit) begin
      if (w_cond_ex && (r_exec_count != 16'hFFFF)) r_exec_count <= r_exec_count + 16'd1;
      if (!w_cond_ex && (r_squash_count != 16'hFFFF)) r_squash_count <= r_squash_count + 16'd1;
    end
  end

  assign exec_count   = r_exec_count;
  assign squash_count = r_squash_count;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit; stats checks are built when COND_UNIT_STATS_EN is set.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, stall_i;
  logic [3:0]  Cond, ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW, NoWrite;
  logic        PCSrc, RegWrite, MemWrite, CondEx, undef_o;
  logic [3:0]  Flags;
`ifdef COND_UNIT_STATS_EN
  logic [15:0] exec_count, squash_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_vec;

  always #5 clk = ~clk;

  cond_unit dut (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_i),
    .stall_i     (stall_i),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .PCS         (PCS),
    .RegW        (RegW),
    .MemW        (MemW),
    .NoWrite     (NoWrite),
    .PCSrc       (PCSrc),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .CondEx      (CondEx),
    .Flags       (Flags),
`ifdef COND_UNIT_STATS_EN
    .exec_count  (exec_count),
    .squash_count(squash_count),
`endif
    .undef_o     (undef_o)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen another unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b1; stall_i = 1'b0; Cond = 4'b1110; ALUFlags = 4'b1111;
    FlagW = 2'b11; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    tick(); tick();
    #1;
    check("reset_flags", {12'd0, Flags}, 16'h0000);
    check("reset_undef", {15'd0, undef_o}, 16'h0000);
    check("reset_pcsrc", {15'd0, PCSrc}, 16'h0000);
    check("reset_regwrite", {15'd0, RegWrite}, 16'h0000);
    check("reset_memwrite", {15'd0, MemWrite}, 16'h0000);

    // Flag-setting compare, then branch on it.
    tick();
    reset = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    RegW = 1'b1; NoWrite = 1'b1; PCS = 1'b0; MemW = 1'b0;
    #1;
    check("cmp_regwrite", {15'd0, RegWrite}, 16'h0000);
    check("cmp_condex", {15'd0, CondEx}, 16'h0001);
    check("cmp_no_bypass", {12'd0, Flags}, 16'h0000);
    tick();
    check("cmp_flags", {12'd0, Flags}, 16'h0004);
    Cond = 4'b0000; FlagW = 2'b00; PCS = 1'b1; RegW = 1'b0; NoWrite = 1'b0;
    #1;
    check("beq_condex", {15'd0, CondEx}, 16'h0001);
    check("beq_pcsrc", {15'd0, PCSrc}, 16'h0001);
    tick();
    Cond = 4'b0001;
    #1;
    check("bne_condex", {15'd0, CondEx}, 16'h0000);
    check("bne_pcsrc", {15'd0, PCSrc}, 16'h0000);

    // EQ passes on old Z while clearing Z; next cycle it fails.
    tick();
    Cond = 4'b0000; PCS = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0000;
    #1;
    check("nobypass_condex", {15'd0, CondEx}, 16'h0001);
    tick();
    FlagW = 2'b00;
    #1;
    check("nobypass_next", {15'd0, CondEx}, 16'h0000);

    // Partial flag write.
    tick();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    check("all_ones", {12'd0, Flags}, 16'h000F);
    FlagW = 2'b01; ALUFlags = 4'b0000;
    tick();
    check("partial_cv", {12'd0, Flags}, 16'h000C);

    // Condition table against Flags = 1100.
    valid_i = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0011;
    exp_vec = 16'h6A99;
    for (int c = 0; c < 16; c++) begin
      Cond = c[3:0];
      #1;
      check($sformatf("tbl1100_c%0d", c), {15'd0, CondEx}, {15'd0, exp_vec[c]});
    end
    tick();
    check("invalid_hold", {12'd0, Flags}, 16'h000C);

    // Failing condition holds flags and suppresses writes.
    valid_i = 1'b1; FlagW = 2'b00; Cond = 4'b1011;
    #1;
    check("lt_condex", {15'd0, CondEx}, 16'h0001);
    tick();
    Cond = 4'b1010; FlagW = 2'b11; ALUFlags = 4'b0011; MemW = 1'b1;
    #1;
    check("ge_condex", {15'd0, CondEx}, 16'h0000);
    check("ge_memwrite", {15'd0, MemWrite}, 16'h0000);
    tick();
    check("ge_flags", {12'd0, Flags}, 16'h000C);

    // Stall for three cycles, then commit exactly once.
    Cond = 4'b1110; MemW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0101; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_memwrite", i), {15'd0, MemWrite}, 16'h0000);
      tick();
      check($sformatf("stall%0d_flags", i), {12'd0, Flags}, 16'h000C);
    end
    stall_i = 1'b0;
    #1;
    check("unstall_memwrite", {15'd0, MemWrite}, 16'h0001);
    tick();
    check("unstall_flags", {12'd0, Flags}, 16'h0005);
    valid_i = 1'b0;
    #1;
    check("after_memwrite", {15'd0, MemWrite}, 16'h0000);

    // Condition table against Flags = 0101.
    exp_vec = 16'h6A69;
    for (int c = 0; c < 16; c++) begin
      Cond = c[3:0];
      #1;
      check($sformatf("tbl0101_c%0d", c), {15'd0, CondEx}, {15'd0, exp_vec[c]});
    end

    // Illegal condition sets sticky undef.
    tick();
    valid_i = 1'b1; Cond = 4'b1111; FlagW = 2'b11; ALUFlags = 4'b1111; MemW = 1'b1;
    #1;
    check("nv_condex", {15'd0, CondEx}, 16'h0000);
    check("nv_undef_pre", {15'd0, undef_o}, 16'h0000);
    tick();
    check("nv_undef", {15'd0, undef_o}, 16'h0001);
    check("nv_flags", {12'd0, Flags}, 16'h0005);
    valid_i = 1'b0; Cond = 4'b1110;
    tick(); tick();
    check("nv_sticky", {15'd0, undef_o}, 16'h0001);

    // Reset beats a simultaneous commit, including a stalled one.
    reset = 1'b1; valid_i = 1'b1; stall_i = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    #1;
    check("rst_memwrite", {15'd0, MemWrite}, 16'h0000);
    tick();
    stall_i = 1'b0;
    #1;
    check("rst_memwrite_commit", {15'd0, MemWrite}, 16'h0000);
    tick();
    check("rst_flags", {12'd0, Flags}, 16'h0000);
    check("rst_undef", {15'd0, undef_o}, 16'h0000);
    reset = 1'b0; FlagW = 2'b00;
    #1;
    check("post_rst_memwrite", {15'd0, MemWrite}, 16'h0001);
    tick();

`ifdef COND_UNIT_STATS_EN
    reset = 1'b1; valid_i = 1'b1; stall_i = 1'b0; Cond = 4'b1110; FlagW = 2'b00; MemW = 1'b0;
    tick();
    check("stats_rst_exec", exec_count, 16'h0000);
    check("stats_rst_squash", squash_count, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("stats_exec3", exec_count, 16'h0003);
    for (int i = 3; i < 70000; i++) tick();
    check("stats_exec_sat", exec_count, 16'hFFFF);
    check("stats_squash", squash_count, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` input, 1 bit, rising-edge clock; `reset` input, 1 bit, synchronous active-high reset.
REQ-002 The block SHALL have these data inputs:
- `valid_i` input, 1: instruction present this cycle.
- `stall_i` input, 1: instruction held, no commit this cycle.
- `Cond` input, 4: instruction condition field, bits 31:28.
- `ALUFlags` input, 4: `{N,Z,C,V}` from the ALU, same cycle.
- `FlagW` input, 2: bit 1 = write N,Z; bit 0 = write C,V.
REQ-003 The block SHALL have these control inputs, each 1 bit, unqualified from the decoder:
- `PCS`: PC write.
- `RegW`: register-file write.
- `MemW`: memory write.
- `NoWrite`: suppress register write (CMP/CMN/TST/TEQ).
REQ-004 The block SHALL have these outputs:
- `PCSrc`, `RegWrite`, `MemWrite`: output, 1 each, qualified writes.
- `CondEx`: output, 1, condition passed.
- `Flags`: output, 4, `{N,Z,C,V}` state register.
- `undef_o`: output, 1, sticky illegal-condition indicator.

Function
REQ-005 `commit` SHALL be defined as `valid_i & ~stall_i & ~reset`.
REQ-006 `CondEx` SHALL be combinational from `Cond` and the registered `Flags` (pre-update value), zero latency:
- 0000 EQ: Z
- 0001 NE: ~Z
- 0010 CS: C
- 0011 CC: ~C
- 0100 MI: N
- 0101 PL: ~N
- 0110 VS: V
- 0111 VC: ~V
- 1000 HI: C & ~Z
- 1001 LS: ~C | Z
- 1010 GE: N == V
- 1011 LT: N != V
- 1100 GT: ~Z & (N == V)
- 1101 LE: Z | (N != V)
- 1110 AL: 1
- 1111: 0
REQ-007 The write outputs SHALL be qualified as follows:
- `PCSrc` = `PCS & CondEx & commit`.
- `MemWrite` = `MemW & CondEx & commit`.
- `RegWrite` = `RegW & ~NoWrite & CondEx & commit`.
REQ-008 On a clock edge with `commit & CondEx & FlagW[1]`, `Flags[3:2]` SHALL load `ALUFlags[3:2]`.
REQ-009 On a clock edge with `commit & CondEx & FlagW[0]`, `Flags[1:0]` SHALL load `ALUFlags[1:0]`.
REQ-010 `FlagW` bits SHALL act independently; `FlagW`=2'b11 updates all four flags in one cycle.
REQ-011 When `CondEx`=0, `stall_i`=1 or `valid_i`=0, `Flags` SHALL hold its value and all write outputs SHALL be 0.
REQ-012 A flag update SHALL be visible to the condition check of the next cycle only, never the same cycle (no bypass).
REQ-013 `undef_o` SHALL set on the edge after `commit` with `Cond`=4'b1111, and SHALL remain 1 until reset.
REQ-014 A stalled instruction SHALL be re-evaluated each cycle against the current `Flags` and SHALL commit exactly once, on the first non-stalled cycle.

Reset
REQ-015 While `reset`=1, on the clock edge the block SHALL set `Flags`=4'b0000 and `undef_o`=0.
REQ-016 While `reset`=1, `PCSrc`, `RegWrite` and `MemWrite` SHALL be forced to 0 combinationally.
REQ-017 `reset` SHALL take priority over any simultaneous `commit`, so no flag update occurs in a reset cycle.
REQ-018 Reset asserted mid-stall SHALL discard the stalled instruction; the block SHALL require no recovery cycle after reset deasserts.

Configuration
REQ-019 The macro `COND_UNIT_STATS_EN` SHALL control an optional statistics feature.
REQ-020 When `COND_UNIT_STATS_EN` is defined, the block SHALL add outputs `exec_count` (16 bits, count of commits with `CondEx`=1) and `squash_count` (16 bits, count of commits with `CondEx`=0).
REQ-021 When `COND_UNIT_STATS_EN` is defined, both counters SHALL reset to 0, SHALL increment by at most 1 per cycle, and SHALL saturate at 16'hFFFF with no wrap.
REQ-022 When `COND_UNIT_STATS_EN` is undefined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover at least these scenarios:
- Flags write then branch: reset; `Cond`=1110, `FlagW`=11, `ALUFlags`=0100, `RegW`=1, `NoWrite`=1 -> `RegWrite`=0, `Flags`=0100 next cycle. Then `Cond`=0000, `PCS`=1 -> `CondEx`=1, `PCSrc`=1. Then `Cond`=0001 -> `PCSrc`=0.
- Partial flag write: `Flags`=1111; `Cond`=1110, `FlagW`=01, `ALUFlags`=0000 -> `Flags`=1100.
- Failed condition holds flags: `Flags`=1100, `Cond`=1011 (LT, N!=V true), then `Cond`=1010 with `FlagW`=11, `ALUFlags`=0011 -> `CondEx`=0, `Flags` stays 1100, `MemWrite`=0.
- Stall: `Cond`=1110, `MemW`=1, `FlagW`=11, `stall_i`=1 for 3 cycles then 0 -> `MemWrite`=0 for 3 cycles, then exactly one cycle of 1, with `Flags` updated once.
- Illegal condition and reset: `Cond`=1111 committed -> `CondEx`=0, `undef_o`=1 next cycle and sticky. Then `reset` with `valid_i`=1, `FlagW`=11 -> `Flags`=0000, `undef_o`=0.
- With `COND_UNIT_STATS_EN`: 70000 AL commits -> `exec_count`=16'hFFFF (saturated), `squash_count`=0.
